// File: rtl/pulse_train_generator.sv
// pulse_train_generator
// Emits a train of N rising edges on dout, each pulse H clocks high and
// separated by L clocks low. Config is captured on an accepted start; the
// requester sees busy for the whole train and a one-cycle done strobe.
//
// Handshake: start is a request that is sampled only in IDLE; it is accepted
// on the clock edge where state==IDLE and start==1, and busy rises on that
// same edge. Requests presented while busy is high (including the DONE cycle)
// are dropped, not queued. abort cancels any non-IDLE state on the next edge
// and has priority over every other transition; in IDLE it has no effect.
module pulse_train_generator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic             abort,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] l_q;
    // Clocks spent in the current HIGH/LOW phase, starting at 1 on entry, so
    // a phase of width W ends on the edge where phase_cnt == W. This keeps the
    // maximum width 2^CNT_W-1 representable without wrap.
    logic [CNT_W-1:0] phase_cnt;

    // Current state is exported as-is for checkers and debug.
    assign state_dbg = state;

    // Train sequencer: state, latched config, phase counter and all outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            n_q         <= '0;
            h_q         <= '0;
            l_q         <= '0;
            phase_cnt   <= '0;
            dout        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else if (state != S_IDLE && abort) begin
            // Cancel: drop to IDLE, keep the edge count for the requester.
            state <= S_IDLE;
            dout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q       <= num_pulses;
                        // A zero width would give no visible phase; treat it as 1.
                        h_q       <= (high_cycles == '0) ? ONE : high_cycles;
                        l_q       <= (low_cycles == '0) ? ONE : low_cycles;
                        phase_cnt <= ONE;
                        busy      <= 1'b1;
                        if (num_pulses != '0) begin
                            state       <= S_HIGH;
                            dout        <= 1'b1;
                            pulses_sent <= ONE;
                        end else begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            pulses_sent <= '0;
                        end
                    end
                end
                S_HIGH: begin
                    if (phase_cnt >= h_q) begin
                        dout      <= 1'b0;
                        phase_cnt <= ONE;
                        if (pulses_sent < n_q) begin
                            state <= S_LOW;
                        end else begin
                            // Last pulse: no trailing low phase.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + ONE;
                    end
                end
                S_LOW: begin
                    if (phase_cnt >= l_q) begin
                        state       <= S_HIGH;
                        dout        <= 1'b1;
                        phase_cnt   <= ONE;
                        pulses_sent <= pulses_sent + ONE;
                    end else begin
                        phase_cnt <= phase_cnt + ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator. Expected waveforms come from a
// small arithmetic model of the train (pulse i rises at i*(H+L), high H).
module tb_pulse_train_generator;

    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [CNT_W-1:0] num_pulses;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic             abort;
    logic             dout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    pulse_train_generator #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .num_pulses  (num_pulses),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .abort       (abort),
        .dout        (dout),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int exp_ps);
        check({tag, " dout"}, 32'(dout), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " pulses_sent"}, 32'(pulses_sent), exp_ps);
    endtask

    // Start a train and follow it cycle by cycle to IDLE. If restart_at >= 0,
    // a start with N=1 is presented for one cycle at that cycle offset and
    // must have no effect.
    task automatic run_train(input string tag, input int n, input int h, input int l,
                             input int restart_at);
        int he, le, p, span;
        he   = (h == 0) ? 1 : h;
        le   = (l == 0) ? 1 : l;
        p    = he + le;
        span = (n == 0) ? 0 : n * he + (n - 1) * le;
        num_pulses  = CNT_W'(n);
        high_cycles = CNT_W'(h);
        low_cycles  = CNT_W'(l);
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < span; t++) begin
            check($sformatf("%s t%0d dout", tag, t), 32'(dout), ((t % p) < he) ? 1 : 0);
            check($sformatf("%s t%0d busy", tag, t), 32'(busy), 1);
            check($sformatf("%s t%0d done", tag, t), 32'(done), 0);
            check($sformatf("%s t%0d pulses_sent", tag, t), 32'(pulses_sent), t / p + 1);
            start = (t == restart_at);
            if (t == restart_at) begin
                num_pulses  = 8'd1;
                high_cycles = 8'd1;
                low_cycles  = 8'd1;
            end
            tick();
        end
        check({tag, " done strobe"}, 32'(done), 1);
        check({tag, " done busy"}, 32'(busy), 1);
        check({tag, " done dout"}, 32'(dout), 0);
        check({tag, " done pulses_sent"}, 32'(pulses_sent), n);
        start = (restart_at == span);
        num_pulses = 8'd1;
        tick();
        start = 1'b0;
        check_idle({tag, " after done"}, n);
        tick();
        check_idle({tag, " hold"}, n);
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_pulses  = '0;
        high_cycles = '0;
        low_cycles  = '0;
        #12;
        check_idle("reset", 0);
        check("reset state", 32'(state_dbg), 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check_idle("post reset", 0);

        // Basic train, with a start presented during DONE that must be dropped.
        run_train("basic", 3, 2, 3, 12);

        // Zero cases.
        run_train("n0", 0, 4, 4, -1);
        run_train("h0l0", 2, 0, 0, -1);

        // Restart request mid-train is ignored: exactly 4 pulses.
        run_train("restart", 4, 1, 1, 3);

        // Abort during the 3rd HIGH phase (t=10..12 for H=3, L=2).
        num_pulses  = 8'd5;
        high_cycles = 8'd3;
        low_cycles  = 8'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 10; t++) begin
            check($sformatf("abort t%0d dout", t), 32'(dout), ((t % 5) < 3) ? 1 : 0);
            if (t < 10) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort next", 3);
        check("abort state", 32'(state_dbg), 0);
        tick();
        check_idle("abort no done", 3);
        run_train("post abort", 1, 2, 2, -1);

        // abort in IDLE does not block a simultaneous start.
        num_pulses  = 8'd1;
        high_cycles = 8'd2;
        low_cycles  = 8'd1;
        start       = 1'b1;
        abort       = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("idle abort busy", 32'(busy), 1);
        check("idle abort dout", 32'(dout), 1);
        tick();
        check("idle abort dout2", 32'(dout), 1);
        tick();
        check("idle abort done", 32'(done), 1);
        tick();
        check_idle("idle abort end", 1);

        // Async reset between edges during a HIGH phase.
        num_pulses  = 8'd3;
        high_cycles = 8'd4;
        low_cycles  = 8'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre reset dout", 32'(dout), 1);
        #2;
        resetn = 1'b0;
        #1;
        check_idle("async reset", 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_idle($sformatf("after reset c%0d", t), 0);
        end

        // Maximum widths.
        run_train("max", 2, 255, 255, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
